alu_operand_stage: RTL

Registered operand-preparation stage directly upstream of the ALU's `logic_shift` unit and the other ALU function units. It accepts an opcode and two operands from register-file read through a valid/ready handshake. It decodes shift opcodes into the shifter's direction-plus-amount control word and pre-resolves out-of-range shift amounts. It presents the result to the ALU through a two-entry skid buffer, so both sides run at one transaction per cycle with fully registered handshake outputs.

---
 rtl/alu_operand_stage_if.sv | 29 ++
 rtl/alu_operand_stage.sv | 105 ++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
// Handshake bundle between register-file read, the operand stage and the ALU.
// The master modport is the environment; the slave modport is the stage itself.
interface alu_operand_stage_if #(
  parameter int BUS_WIDTH      = 8,
  parameter int BUS_WIDTH_BITS = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                in_op;
  logic [BUS_WIDTH-1:0]      in_a;
  logic [BUS_WIDTH-1:0]      in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [2:0]                out_op;
  logic [BUS_WIDTH-1:0]      out_a;
  logic [BUS_WIDTH-1:0]      out_b;
  logic [BUS_WIDTH_BITS:0]   out_shctl;
  logic                      out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_op, out_a, out_b, out_shctl, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_op, out_a, out_b, out_shctl, out_err
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-preparation stage: decodes shift control, zeroes A on out-of-range shifts,
// and hands results to the ALU through a two-entry skid buffer with registered handshakes.
module alu_operand_stage #(
  parameter int BUS_WIDTH      = 8,
  parameter int BUS_WIDTH_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  alu_operand_stage_if.slave   bus
);

  typedef struct packed {
    logic [2:0]              op;
    logic [BUS_WIDTH-1:0]    a;
    logic [BUS_WIDTH-1:0]    b;
    logic [BUS_WIDTH_BITS:0] shctl;
    logic                    err;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t dec;
  logic   valid_q;
  logic   ready_q;
  logic   acc;
  logic   pop;

  assign acc = bus.in_valid & ready_q;
  assign pop = valid_q & bus.out_ready;

  // Illegal opcodes (bit 3 set) alias legal low bits but must never steer the shifter.
  always_comb begin
    dec       = '0;
    dec.op    = bus.in_op[2:0];
    dec.a     = bus.in_a;
    dec.b     = bus.in_b;
    dec.err   = bus.in_op[3];
    if (!bus.in_op[3] && (bus.in_op[2:0] == 3'd5 || bus.in_op[2:0] == 3'd6)) begin
      dec.shctl = {bus.in_op[2:0] == 3'd5, bus.in_b[BUS_WIDTH_BITS-1:0]};
      if (|bus.in_b[BUS_WIDTH-1:BUS_WIDTH_BITS])
        dec.a = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q  <= dec;
            state   <= ONE;
            valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            skid_q  <= dec;
            state   <= TWO;
            ready_q <= 1'b0;
          end else if (acc && pop) begin
            main_q  <= dec;
          end else if (pop) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            main_q  <= skid_q;
            state   <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_op    = main_q.op;
  assign bus.out_a     = main_q.a;
  assign bus.out_b     = main_q.b;
  assign bus.out_shctl = main_q.shctl;
  assign bus.out_err   = main_q.err;

endmodule
